shift_chain_ctrl: RTL and testbench

- Sequencer for an external DEPTH-stage D-flip-flop shift chain: one serial input `d`, one serial output `q`, one shared clock.
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first into the chain.
- Waits out the chain latency, deserializes the returning bits, and presents the captured word with a loopback-mismatch flag.
- Used for chain bring-up, integrity checking, and as the single owner that sequences access to the chain.

---
 rtl/shift_chain_ctrl_pkg.sv | 15 +
 rtl/shift_chain_ctrl.sv | 103 ++++++++++
 tb/tb_shift_chain_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/shift_chain_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-chain sequencer.
package shift_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Counter must reach WIDTH+DEPTH inclusive.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/shift_chain_ctrl.sv
// Serializes a word MSB-first into an external DEPTH-stage flop chain,
// captures the returning bits and flags any loopback mismatch.
module shift_chain_ctrl
    import shift_chain_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             mismatch,
    output logic             busy
);

    if (WIDTH < 2 || DEPTH < 1) begin : g_bad_params
        $error("shift_chain_ctrl: WIDTH must be >= 2 and DEPTH >= 1");
    end

    localparam int CW = cnt_width(WIDTH, DEPTH);
    localparam logic [CW-1:0] TX_LAST  = CW'(WIDTH);
    localparam logic [CW-1:0] RX_FIRST = CW'(DEPTH + 1);
    localparam logic [CW-1:0] RX_LAST  = CW'(WIDTH + DEPTH);

    state_e           state_q;
    logic [WIDTH-2:0] tx_sr_q;
    logic [WIDTH-2:0] rx_sr_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    cyc_q;
    logic             ser_out_q;
    logic             mismatch_q;
    logic [WIDTH-1:0] rx_word_d;

    // The MSB is driven straight from in_data on accept, so only the
    // remaining WIDTH-1 bits are kept in tx_sr; rx_sr likewise omits the
    // bit that is still arriving on ser_in.
    assign rx_word_d = {rx_sr_q, ser_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            ref_q      <= '0;
            out_data_q <= '0;
            cyc_q      <= '0;
            ser_out_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tx_sr_q   <= in_data[WIDTH-2:0];
                        ref_q     <= in_data;
                        ser_out_q <= in_data[WIDTH-1];
                        rx_sr_q   <= '0;
                        cyc_q     <= CW'(1);
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (cyc_q < TX_LAST) begin
                        ser_out_q <= tx_sr_q[WIDTH-2];
                        tx_sr_q   <= tx_sr_q << 1;
                    end else begin
                        ser_out_q <= 1'b0;
                    end
                    if (cyc_q >= RX_FIRST) begin
                        rx_sr_q <= rx_word_d[WIDTH-2:0];
                    end
                    cyc_q <= cyc_q + CW'(1);
                    if (cyc_q == RX_LAST) begin
                        out_data_q <= rx_word_d;
                        mismatch_q <= (rx_word_d != ref_q);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign ser_out   = ser_out_q;
    assign out_data  = out_data_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Loopback bench: DUT drives a DEPTH-flop chain whose output feeds ser_in.
module tb_shift_chain_ctrl;

    localparam int W = 8;
    localparam int D = 3;
    localparam int P = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         ser_out;
    logic         ser_in;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         mismatch;
    logic         busy;

    logic [D-1:0] chain = '0;
    logic         stuck2 = 1'b0;
    logic         pend_v = 1'b0;
    logic [W-1:0] pend_d = '0;
    time          t_acc;
    int           checks = 0;
    int           failures = 0;

    shift_chain_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .ser_in    (ser_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mismatch  (mismatch),
        .busy      (busy)
    );

    always #(P/2) clk = ~clk;

    // External chain; stage 2 can be held stuck-at-0.
    always @(posedge clk) begin
        chain[0] <= ser_out;
        for (int i = 1; i < D; i++)
            chain[i] <= (stuck2 && i == 1) ? 1'b0 : chain[i-1];
    end
    assign ser_in = chain[D-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level model of what the loop returns.
    function automatic logic [W-1:0] loop_model(input logic [W-1:0] w, input logic stuck);
        return stuck ? '0 : w;
    endfunction

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic send(input logic [W-1:0] w, input int stall, input logic stuck);
        int           n;
        logic [W-1:0] exp_word;
        exp_word  = loop_model(w, stuck);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = w;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid = pend_v;
        in_data  = pend_d;
        for (int k = 0; k < W + D; k++) begin
            if (k < W) check_eq("ser_bit", ser_out, w[W-1-k]);
            else       check_eq("ser_idle", ser_out, 0);
            check_eq("ovalid_run", out_valid, 0);
            check_eq("busy_ready_run", {busy, in_ready}, 2'b10);
            @(negedge clk);
        end
        check_eq("ovalid", out_valid, 1);
        check_eq("odata", out_data, exp_word);
        check_eq("mismatch", mismatch, (exp_word != w));
        check_eq("iready_done", in_ready, 0);
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check_eq("ovalid_hold", out_valid, 1);
            check_eq("odata_hold", out_data, exp_word);
            check_eq("iready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("ovalid_clr", out_valid, 0);
        check_eq("idle_ready", {busy, in_ready}, 2'b01);
    endtask

    initial begin
        time t1;
        logic [W-1:0] w;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_state", {in_ready, out_valid, ser_out, busy, mismatch}, 5'b10000);
        check_eq("rst_odata", out_data, 0);

        // Basic word
        send(8'hA5, 0, 1'b0);

        // Stalled consumer with a competing word pending
        pend_v = 1'b1;
        pend_d = 8'hFF;
        send(8'h3C, 5, 1'b0);
        pend_v = 1'b0;
        send(8'hFF, 0, 1'b0);

        // Stuck chain stage
        stuck2 = 1'b1;
        send(8'hFF, 0, 1'b0 | 1'b1);
        stuck2 = 1'b0;
        repeat (D) @(negedge clk);

        // Reset in the middle of a transfer
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_state", {in_ready, out_valid, ser_out, busy, mismatch}, 5'b10000);
        check_eq("abort_odata", out_data, 0);
        rst = 1'b0;
        send(8'h7E, 0, 1'b0);

        // Back-to-back with out_ready held high
        send(8'h01, 0, 1'b0);
        t1 = t_acc;
        send(8'h80, 0, 1'b0);
        check_eq("b2b_spacing", 32'((t_acc - t1) / P), W + D + 2);

        // Random words, gaps and stalls
        for (int i = 0; i < 16; i++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(w, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
